micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Microaddress register plus control store for the microprogrammed control unit.
- Each cycle it latches the 5-bit next microaddress computed by the next-address Logic block (from z, ir, na, br).
- It reads the matching microinstruction and returns its na and br fields to the Logic block. It also drives the datapath control bits.
- It adds run/halt sequencing, memory-wait stalls and a control-store load port.

Parameters:
- AW, 5, microaddress width; the store has 2^AW words.
- CTRL_W, 16, datapath control-bit field width.
- FETCH_ADDR, 0, microaddress of FETCH1, the entry point on start.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin or restart execution at FETCH_ADDR.
- next_addr  in  AW  next microaddress from the Logic block.
- mem_ready  in  1  memory handshake; low stalls a mem_req microinstruction.
- load_we  in  1  control-store write enable.
- load_addr  in  AW  control-store write address.
- load_data  in  CTRL_W+8  control-store write data (includes parity bit when parity is compiled in).
- upc  out  AW  current microaddress.
- na  out  AW  next-address field of the current microinstruction, to Logic.
- br  out  1  branch field of the current microinstruction, to Logic.
- ctrl  out  CTRL_W  datapath control bits.
- mem_req  out  1  current microinstruction requests memory.
- stalled  out  1  held this cycle for mem_ready.
- running  out  1  state is RUN.
- halted  out  1  state is HALT.
- err  out  1  sticky control-store parity error.

Behaviour:
- Microword layout: [AW-1:0] na, [AW] br, [AW+1] mem_req, [AW+2] end, [AW+3 +: CTRL_W] ctrl. With parity compiled in, the MSB is the parity bit.
- Internal registers: upc, cw_q (registered microword), and state (IDLE, RUN, HALT).
- cw_q always equals store[upc]: whenever upc is loaded with address A, cw_q is loaded with store[A] on the same edge. The read is synchronous on the address being loaded.
- Reset values: state=IDLE, upc=0, cw_q=0, err=0. All outputs read 0 except those derived from upc and cw_q, which are also 0.
- na and br always come from cw_q in every state. ctrl and mem_req equal the cw_q fields only when running=1; otherwise they are 0.
- IDLE:
  - load_we writes store[load_addr].
  - start moves to RUN, with upc<=FETCH_ADDR and cw_q<=store[FETCH_ADDR].
  - If start and load_we both occur with load_addr==FETCH_ADDR, the write is visible: cw_q gets load_data (write-first).
- RUN, priority order per cycle:
  1. cw_q.end=1: go to HALT; upc and cw_q hold. ctrl is valid for that one cycle.
  2. mem_req=1 and mem_ready=0: stalled=1; upc and cw_q hold; ctrl stays driven.
  3. Otherwise: upc<=next_addr, cw_q<=store[next_addr].
- Each non-stalled, non-end RUN cycle takes exactly one cycle per microinstruction. next_addr is consumed the same cycle it is presented.
- load_we in RUN is ignored; the store is not modified.
- start in RUN is ignored.
- HALT:
  - load_we is allowed.
  - start restarts at FETCH_ADDR exactly as from IDLE.
  - next_addr and mem_ready are ignored.
- Address wrap: upc is AW bits wide. No range check is needed because every value is a valid store index.
- Reset mid-operation (any state, including during a stall) returns all registers to reset values within 1 edge. Store contents are retained.
- stalled is combinational from state, cw_q and mem_ready. It is 0 outside RUN.

Optional Feature:
- Macro: USTORE_PARITY_EN.
- When defined:
  - Stored words are CTRL_W+9 bits wide, including an even-parity bit; load_data width increases to match.
  - Every word loaded into cw_q is parity-checked on the following cycle.
  - On mismatch in RUN: err<=1 (sticky until rst), state<=HALT, and ctrl is forced to 0 in that cycle.
- When undefined: no parity bit, and err is tied to 0.

Test Plan:
- Reset, then load FETCH1@0 {na=1,br=0} and FETCH2@1 {br=1}, then pulse start. Expect upc=0 on the next cycle, then upc=1 after 1 edge with next_addr=1, with running=1.
- Loop with Logic connected, ir=19: load LOAD1@19 {na=20}, LOAD2@20 {na=0}. Expect upc sequence 0,1,19,20,0, one step per cycle, with ctrl matching each stored word.
- mem_req word at upc=19 with mem_ready low for 3 cycles. Expect stalled=1 for 3 cycles, upc held at 19, and ctrl held. Raise mem_ready and expect upc=next_addr on the next edge.
- Word with end=1 at 5. Expect halted=1 with upc=5 held. Then load_we in HALT at addr 2, pulse start, and expect upc=0 with the new store[2] readable later.
- load_we during RUN to addr 1 with different data. On revisiting upc=1, expect the original word.
- With USTORE_PARITY_EN, load a bad-parity word at 1. On execution expect err=1, halted=1 and ctrl=0. Assert rst and expect err=0.

Source files
------------

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer
// Description : Microaddress register, control store and run/halt sequencer
//               for a microprogrammed control unit. Latches the next
//               microaddress each cycle, returns na/br to the next-address
//               logic, drives datapath control bits, stalls on memory wait
//               and offers a control-store load port in IDLE/HALT.
//               Optional build macro: USTORE_PARITY_EN (even-parity bit per
//               stored word, sticky err, halt on a bad microword).
// Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer #(
  parameter int AW         = 5,
  parameter int CTRL_W     = 16,
  parameter int FETCH_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        next_addr,
  input  logic                 mem_ready,
  input  logic                 load_we,
  input  logic [AW-1:0]        load_addr,
`ifdef USTORE_PARITY_EN
  input  logic [CTRL_W+AW+3:0] load_data,
`else
  input  logic [CTRL_W+AW+2:0] load_data,
`endif
  output logic [AW-1:0]        upc,
  output logic [AW-1:0]        na,
  output logic                 br,
  output logic [CTRL_W-1:0]    ctrl,
  output logic                 mem_req,
  output logic                 stalled,
  output logic                 running,
  output logic                 halted,
  output logic                 err
);

  // Microword field positions: {[parity], ctrl, end, mem_req, br, na}
  localparam int CW_W     = CTRL_W + AW + 3;
`ifdef USTORE_PARITY_EN
  localparam int SW       = CW_W + 1;
`else
  localparam int SW       = CW_W;
`endif
  localparam int DEPTH    = 1 << AW;
  localparam int BR_B     = AW;
  localparam int MREQ_B   = AW + 1;
  localparam int END_B    = AW + 2;
  localparam int CTRL_LSB = AW + 3;
  localparam logic [AW-1:0] FETCH_A = AW'(FETCH_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] upc_q, upc_d;
  logic [SW-1:0] cw_q, cw_d;
  logic          store_we;
  logic [SW-1:0] store_mem [DEPTH];

`ifdef USTORE_PARITY_EN
  logic err_q, err_d;
  logic perr;

  // Even parity over the whole held word, including the parity bit
  assign perr = ^cw_q;
`endif

  // Next-state, microaddress and microword selection
  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    cw_d     = cw_q;
    store_we = 1'b0;
`ifdef USTORE_PARITY_EN
    err_d    = err_q;
`endif
    case (state_q)
      S_RUN: begin
`ifdef USTORE_PARITY_EN
        if (perr) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else
`endif
        if (cw_q[END_B]) begin
          state_d = S_HALT;
        end else if (!(cw_q[MREQ_B] && !mem_ready)) begin
          upc_d = next_addr;
          cw_d  = store_mem[next_addr];
        end
      end
      default: begin
        // IDLE and HALT: store is writable; start enters at FETCH with write-first bypass
        store_we = load_we;
        if (start) begin
          state_d = S_RUN;
          upc_d   = FETCH_A;
          if (load_we && (load_addr == FETCH_A)) begin
            cw_d = load_data;
          end else begin
            cw_d = store_mem[FETCH_A];
          end
        end
      end
    endcase
  end

  // Sequencer state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cw_q    <= cw_d;
    end
  end

`ifdef USTORE_PARITY_EN
  // Sticky parity error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Control store write port; contents survive reset
  always_ff @(posedge clk) begin
    if (store_we && !rst) begin
      store_mem[load_addr] <= load_data;
    end
  end

  assign running = (state_q == S_RUN);
  assign halted  = (state_q == S_HALT);
  assign upc     = upc_q;
  assign na      = cw_q[AW-1:0];
  assign br      = cw_q[BR_B];
  assign mem_req = running ? cw_q[MREQ_B] : 1'b0;

`ifdef USTORE_PARITY_EN
  assign ctrl    = (running && !perr) ? cw_q[CTRL_LSB +: CTRL_W] : '0;
  assign stalled = running && !perr && !cw_q[END_B] && cw_q[MREQ_B] && !mem_ready;
`else
  assign ctrl    = running ? cw_q[CTRL_LSB +: CTRL_W] : '0;
  assign stalled = running && !cw_q[END_B] && cw_q[MREQ_B] && !mem_ready;
`endif

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_sequencer
// Description : Self-checking bench for micro_sequencer. Vector table of
//               per-cycle inputs and expected outputs, expected records
//               queued at drive time and compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

  localparam int AW     = 5;
  localparam int CTRL_W = 16;
`ifdef USTORE_PARITY_EN
  localparam int SW = CTRL_W + AW + 4;
`else
  localparam int SW = CTRL_W + AW + 3;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     next_addr = '0;
  logic              mem_ready = 1'b1;
  logic              load_we = 1'b0;
  logic [AW-1:0]     load_addr = '0;
  logic [SW-1:0]     load_data = '0;
  logic [AW-1:0]     upc;
  logic [AW-1:0]     na;
  logic              br;
  logic [CTRL_W-1:0] ctrl;
  logic              mem_req;
  logic              stalled;
  logic              running;
  logic              halted;
  logic              err;

  int tests = 0;
  int fails = 0;

  micro_sequencer #(.AW(AW), .CTRL_W(CTRL_W), .FETCH_ADDR(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .next_addr (next_addr),
    .mem_ready (mem_ready),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .upc       (upc),
    .na        (na),
    .br        (br),
    .ctrl      (ctrl),
    .mem_req   (mem_req),
    .stalled   (stalled),
    .running   (running),
    .halted    (halted),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              r, s;
    logic [AW-1:0]     nx;
    logic              mr, we;
    logic [AW-1:0]     la;
    logic [SW-1:0]     ld;
    logic [AW-1:0]     e_upc, e_na;
    logic              e_br;
    logic [CTRL_W-1:0] e_ctrl;
    logic              e_mreq, e_stall, e_run, e_halt, e_err;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  // Build a microword {[parity], ctrl, end, mem_req, br, na} with even parity
  function automatic logic [SW-1:0] mkw(input logic [CTRL_W-1:0] c, input logic e,
                                        input logic m, input logic b, input logic [AW-1:0] n);
    logic [CTRL_W+AW+2:0] w;
    w = {c, e, m, b, n};
`ifdef USTORE_PARITY_EN
    mkw = {^w, w};
`else
    mkw = w;
`endif
  endfunction

  task automatic v(input logic r, input logic s, input logic [AW-1:0] nx, input logic mr,
                   input logic we, input logic [AW-1:0] la, input logic [SW-1:0] ld,
                   input logic [AW-1:0] eu, input logic [AW-1:0] en, input logic eb,
                   input logic [CTRL_W-1:0] ec, input logic em, input logic es,
                   input logic erun, input logic eh, input logic ee);
    vec_t t;
    t.r = r; t.s = s; t.nx = nx; t.mr = mr; t.we = we; t.la = la; t.ld = ld;
    t.e_upc = eu; t.e_na = en; t.e_br = eb; t.e_ctrl = ec; t.e_mreq = em;
    t.e_stall = es; t.e_run = erun; t.e_halt = eh; t.e_err = ee;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
    end
  endtask

  logic [SW-1:0] w0, w1, w19, w20, w5, wx, w2, wf;
`ifdef USTORE_PARITY_EN
  logic [SW-1:0] wbad;
`endif

  initial begin
    vec_t e;
    w0  = mkw(16'h1111, 1'b0, 1'b0, 1'b0, 5'd1);
    w1  = mkw(16'h2222, 1'b0, 1'b0, 1'b1, 5'd0);
    w19 = mkw(16'h1919, 1'b0, 1'b1, 1'b0, 5'd20);
    w20 = mkw(16'h2020, 1'b0, 1'b0, 1'b0, 5'd0);
    w5  = mkw(16'h5555, 1'b1, 1'b0, 1'b0, 5'd3);
    wx  = mkw(16'hDEAD, 1'b0, 1'b0, 1'b0, 5'd7);
    w2  = mkw(16'h0202, 1'b0, 1'b0, 1'b0, 5'd9);
    wf  = mkw(16'hF0F0, 1'b0, 1'b0, 1'b0, 5'd2);

    //  r s  nx mr we la ld     upc na br ctrl     mq st rn hl er
    v(1,0, 0, 1, 0, 0, '0,     0,  0, 0, 16'h0,    0, 0, 0, 0, 0);   // reset state
    v(1,0, 0, 1, 0, 0, '0,     0,  0, 0, 16'h0,    0, 0, 0, 0, 0);
    v(0,0, 0, 1, 1, 0, w0,     0,  0, 0, 16'h0,    0, 0, 0, 0, 0);   // IDLE loads
    v(0,0, 0, 1, 1, 1, w1,     0,  0, 0, 16'h0,    0, 0, 0, 0, 0);
    v(0,0, 0, 1, 1, 19, w19,   0,  0, 0, 16'h0,    0, 0, 0, 0, 0);
    v(0,0, 0, 1, 1, 20, w20,   0,  0, 0, 16'h0,    0, 0, 0, 0, 0);
    v(0,0, 0, 1, 1, 5, w5,     0,  0, 0, 16'h0,    0, 0, 0, 0, 0);
    v(0,1, 0, 1, 0, 0, '0,     0,  1, 0, 16'h1111, 0, 0, 1, 0, 0);   // start -> FETCH1
    v(0,0, 1, 1, 0, 0, '0,     1,  0, 1, 16'h2222, 0, 0, 1, 0, 0);   // FETCH2
    v(0,0, 19, 1, 0, 0, '0,    19, 20, 0, 16'h1919, 1, 0, 1, 0, 0);  // mem word, ready
    v(0,0, 20, 0, 0, 0, '0,    19, 20, 0, 16'h1919, 1, 1, 1, 0, 0);  // stall x3
    v(0,0, 20, 0, 0, 0, '0,    19, 20, 0, 16'h1919, 1, 1, 1, 0, 0);
    v(0,0, 20, 0, 0, 0, '0,    19, 20, 0, 16'h1919, 1, 1, 1, 0, 0);
    v(0,0, 20, 1, 1, 1, wx,    20, 0, 0, 16'h2020, 0, 0, 1, 0, 0);   // release; RUN write ignored
    v(0,0, 0, 1, 0, 0, '0,     0,  1, 0, 16'h1111, 0, 0, 1, 0, 0);
    v(0,1, 1, 1, 0, 0, '0,     1,  0, 1, 16'h2222, 0, 0, 1, 0, 0);   // start ignored, original word
    v(0,0, 5, 1, 0, 0, '0,     5,  3, 0, 16'h5555, 0, 0, 1, 0, 0);   // end word
    v(0,0, 7, 0, 0, 0, '0,     5,  3, 0, 16'h0,    0, 0, 0, 1, 0);   // halted, held
    v(0,0, 9, 1, 1, 2, w2,     5,  3, 0, 16'h0,    0, 0, 0, 1, 0);   // HALT load
    v(0,1, 0, 1, 0, 0, '0,     0,  1, 0, 16'h1111, 0, 0, 1, 0, 0);   // restart
    v(0,0, 2, 1, 0, 0, '0,     2,  9, 0, 16'h0202, 0, 0, 1, 0, 0);   // new store[2]
    v(0,0, 5, 1, 0, 0, '0,     5,  3, 0, 16'h5555, 0, 0, 1, 0, 0);
    v(0,0, 0, 1, 0, 0, '0,     5,  3, 0, 16'h0,    0, 0, 0, 1, 0);
    v(0,1, 0, 1, 1, 0, wf,     0,  2, 0, 16'hF0F0, 0, 0, 1, 0, 0);   // write-first on start
    v(0,0, 0, 1, 0, 0, '0,     0,  2, 0, 16'hF0F0, 0, 0, 1, 0, 0);
    v(0,0, 19, 1, 0, 0, '0,    19, 20, 0, 16'h1919, 1, 0, 1, 0, 0);
    v(0,0, 20, 0, 0, 0, '0,    19, 20, 0, 16'h1919, 1, 1, 1, 0, 0);
    v(1,0, 20, 0, 0, 0, '0,    0,  0, 0, 16'h0,    0, 0, 0, 0, 0);   // reset during stall
    v(0,1, 0, 1, 0, 0, '0,     0,  2, 0, 16'hF0F0, 0, 0, 1, 0, 0);   // store retained
`ifdef USTORE_PARITY_EN
    wbad = w1;
    wbad[SW-1] = ~wbad[SW-1];
    v(1,0, 0, 1, 0, 0, '0,     0,  0, 0, 16'h0,    0, 0, 0, 0, 0);
    v(0,0, 0, 1, 1, 1, wbad,   0,  0, 0, 16'h0,    0, 0, 0, 0, 0);   // bad parity at 1
    v(0,1, 0, 1, 0, 0, '0,     0,  2, 0, 16'hF0F0, 0, 0, 1, 0, 0);
    v(0,0, 1, 1, 0, 0, '0,     1,  0, 1, 16'h0,    0, 0, 1, 0, 0);   // ctrl forced 0
    v(0,0, 0, 1, 0, 0, '0,     1,  0, 1, 16'h0,    0, 0, 0, 1, 1);   // err, halted
    v(0,0, 0, 1, 0, 0, '0,     1,  0, 1, 16'h0,    0, 0, 0, 1, 1);   // sticky
    v(1,0, 0, 1, 0, 0, '0,     0,  0, 0, 16'h0,    0, 0, 0, 0, 0);   // rst clears err
`endif

    foreach (tbl[i]) begin
      rst       = tbl[i].r;
      start     = tbl[i].s;
      next_addr = tbl[i].nx;
      mem_ready = tbl[i].mr;
      load_we   = tbl[i].we;
      load_addr = tbl[i].la;
      load_data = tbl[i].ld;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard step %0d: got empty queue expected entry", i);
      end else begin
        e = exp_q.pop_front();
        chk("upc",     i, 32'(upc),     32'(e.e_upc));
        chk("na",      i, 32'(na),      32'(e.e_na));
        chk("br",      i, 32'(br),      32'(e.e_br));
        chk("ctrl",    i, 32'(ctrl),    32'(e.e_ctrl));
        chk("mem_req", i, 32'(mem_req), 32'(e.e_mreq));
        chk("stalled", i, 32'(stalled), 32'(e.e_stall));
        chk("running", i, 32'(running), 32'(e.e_run));
        chk("halted",  i, 32'(halted),  32'(e.e_halt));
        chk("err",     i, 32'(err),     32'(e.e_err));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
